seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 26 ++
 rtl/bcd7seg.sv | 29 ++
 rtl/seg_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants for the multiplexed 7-segment scan controller
// Segment bit order is a(6) b(5) c(4) d(3) e(2) f(1) g(0), active high.
package seg_pkg;

  localparam int N_DIG = 4;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [3:0] an_onehot_low(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd7seg.sv
// rtl/bcd7seg.sv - BCD nibble to 7-segment pattern decoder
// Ports:
//   cin [3:0]  BCD digit; values 10..15 decode to all segments off
//   seg [6:0]  active-high segments a..g
module bcd7seg
  import seg_pkg::*;
(
  input  logic [3:0] cin,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (cin)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit multiplexed 7-segment scan controller with frame-synchronous update
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   en         display enable; low blanks an/seg
//   lzb        leading-zero blanking enable
//   load       one-cycle strobe capturing din into the pending register
//   din [15:0] four BCD digits, [3:0] is digit0 (least significant)
//   ready      high when no update is pending
//   an [3:0]   active-low digit enables, an[i] selects digit i
//   seg [6:0]  active-high segments a..g
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int N_DIG = seg_pkg::N_DIG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        lzb,
  input  logic        load,
  input  logic [15:0] din,
  output logic        ready,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam logic [15:0] CNT_MAX = 16'(DIV - 1);

  logic [15:0]      cnt;
  logic [1:0]       idx;
  logic             tick;
  logic             frame_end;
  logic [15:0]      pending;
  logic [15:0]      display;
  logic [N_DIG-1:0] blank;
  logic             zero_run;
  logic [3:0]       cur_digit;
  logic [6:0]       dec_seg;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;

  assign tick      = (cnt == CNT_MAX);
  assign frame_end = tick && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (tick) begin
      idx <= idx + 2'd1;
    end
  end

  // Display only changes at frame boundaries so a digit never tears mid-scan.
  // A load landing on frame_end still lets the old pending value through,
  // while the new one waits for the next frame with ready held low.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      display <= '0;
      ready   <= 1'b1;
    end else begin
      if (frame_end) begin
        display <= pending;
      end
      if (load) begin
        pending <= din;
        ready   <= 1'b0;
      end else if (frame_end) begin
        ready <= 1'b1;
      end
    end
  end

  // Walk from the most significant digit down; a digit is blanked only while
  // every digit above it (and itself) is zero. Digit 0 always shows.
  always_comb begin
    blank    = '0;
    zero_run = lzb;
    for (int i = N_DIG - 1; i >= 1; i--) begin
      zero_run = zero_run && (display[4*i +: 4] == 4'd0);
      blank[i] = zero_run;
    end
  end

  assign cur_digit = display[{idx, 2'b00} +: 4];

  bcd7seg u_dec (
    .cin (cur_digit),
    .seg (dec_seg)
  );

  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_BLANK;
    if (en && !blank[idx]) begin
      an_nxt  = an_onehot_low(idx);
      seg_nxt = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl (DIV=4)
module tb_seg_scan_ctrl;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] S9 = 7'b1111011;
  localparam logic [6:0] SB = 7'b0000000;

  logic        clk;
  logic        rst;
  logic        en;
  logic        lzb;
  logic        load;
  logic [15:0] din;
  logic        ready;
  logic [3:0]  an;
  logic [6:0]  seg;

  int n_cmp;
  int n_err;
  int cyc;
  int seen7;

  seg_scan_ctrl #(.DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .lzb   (lzb),
    .load  (load),
    .din   (din),
    .ready (ready),
    .an    (an),
    .seg   (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // cyc counts rising edges since reset was last released.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic run_to_watch7(input int k);
    while (cyc < k) begin
      step();
      if (seg === S7) seen7++;
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    chk({tag, "_an"}, {12'd0, an}, {12'd0, exp_an});
    chk({tag, "_seg"}, {9'd0, seg}, {9'd0, exp_seg});
  endtask

  initial begin
    logic [3:0] exp_an;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    seen7 = 0;
    rst   = 1'b1;
    en    = 1'b1;
    lzb   = 1'b0;
    load  = 1'b0;
    din   = 16'h0000;

    // reset state
    step();
    step();
    chk("rst_ready", {15'd0, ready}, 16'd1);
    chk_out("rst", 4'b1111, SB);

    // free scan with display=0000, lzb=0
    rst = 1'b0;
    cyc = 0;
    step();
    chk_out("first_after_rst", 4'b1110, S0);
    for (int k = 2; k <= 16; k++) begin
      step();
      exp_an = ~(4'b0001 << ((k - 1) / 4));
      chk($sformatf("scan_k%0d", k), {12'd0, an}, {12'd0, exp_an});
      chk($sformatf("scan_seg_k%0d", k), {9'd0, seg}, {9'd0, S0});
    end

    // load 1234 mid-frame
    run_to(18);
    load = 1'b1;
    din  = 16'h1234;
    step();
    load = 1'b0;
    chk("ready_low_after_load", {15'd0, ready}, 16'd0);
    run_to(31);
    chk("ready_low_before_fe", {15'd0, ready}, 16'd0);
    run_to(32);
    chk("ready_high_after_fe", {15'd0, ready}, 16'd1);
    run_to(33);
    chk_out("d0_of_1234", 4'b1110, S4);
    run_to(37);
    chk_out("d1_of_1234", 4'b1101, S3);
    run_to(41);
    chk_out("d2_of_1234", 4'b1011, S2);
    run_to(45);
    chk_out("d3_of_1234", 4'b0111, S1);

    // load 0007 then overwrite with 0009 before frame_end
    run_to(50);
    load = 1'b1;
    din  = 16'h0007;
    step();
    load = 1'b0;
    run_to_watch7(54);
    load = 1'b1;
    din  = 16'h0009;
    step();
    load = 1'b0;
    run_to_watch7(64);
    chk("ready_after_overwrite", {15'd0, ready}, 16'd1);
    run_to_watch7(65);
    chk_out("d0_of_0009", 4'b1110, S9);
    run_to_watch7(69);
    chk_out("d1_of_0009", 4'b1101, S0);
    run_to_watch7(80);
    chk("seven_never_shown", 16'(seen7), 16'd0);

    // leading-zero blanking with 0050
    lzb = 1'b1;
    run_to(82);
    load = 1'b1;
    din  = 16'h0050;
    step();
    load = 1'b0;
    run_to(97);
    chk_out("lzb_d0", 4'b1110, S0);
    run_to(98);
    load = 1'b1;
    din  = 16'hA000;
    step();
    load = 1'b0;
    run_to(101);
    chk_out("lzb_d1", 4'b1101, S5);
    run_to(105);
    chk_out("lzb_d2", 4'b1111, SB);
    run_to(109);
    chk_out("lzb_d3", 4'b1111, SB);

    // A000: nonzero digit3 keeps lower zeros visible, invalid nibble blank
    run_to(113);
    chk_out("a000_d0", 4'b1110, S0);
    run_to(117);
    chk_out("a000_d1", 4'b1101, S0);
    run_to(125);
    chk_out("a000_d3", 4'b0111, SB);

    // en=0 mid-scan, index keeps running
    run_to(126);
    en = 1'b0;
    step();
    chk_out("en_off", 4'b1111, SB);
    run_to(130);
    en   = 1'b1;
    load = 1'b1;
    din  = 16'h0321;
    step();
    load = 1'b0;
    chk_out("en_on_idx_advanced", 4'b1110, S0);
    chk("ready_low_0321", {15'd0, ready}, 16'd0);

    // load on the exact frame_end cycle
    run_to(143);
    load = 1'b1;
    din  = 16'h0456;
    step();
    load = 1'b0;
    chk("ready_low_load_on_fe", {15'd0, ready}, 16'd0);
    run_to(145);
    chk_out("old_pending_d0", 4'b1110, S1);
    run_to(149);
    chk_out("old_pending_d1", 4'b1101, S2);

    // reset mid-frame discards pending, load ignored during reset
    run_to(150);
    rst  = 1'b1;
    load = 1'b1;
    din  = 16'h0999;
    step();
    chk("midrst_ready", {15'd0, ready}, 16'd1);
    chk_out("midrst", 4'b1111, SB);
    rst  = 1'b0;
    load = 1'b0;
    cyc  = 0;
    step();
    chk_out("after_midrst", 4'b1110, S0);
    run_to(16);
    chk("ready_after_midrst_fe", {15'd0, ready}, 16'd1);
    run_to(17);
    chk_out("discarded_d0", 4'b1110, S0);
    run_to(21);
    chk_out("discarded_d1", 4'b1111, SB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
